// File: rtl/axi_llc_read_unit.sv
// Read unit of the LLC: turns read descriptors into per-beat data-way reads,
// pairs the returned way data with in-order beat metadata and emits AXI R beats.
package axi_llc_read_pkg;
   localparam int unsigned IdWidth           = 4;
   localparam int unsigned AddrWidth         = 16;
   localparam int unsigned DataWidth         = 64;
   localparam int unsigned IndexLength       = 5;
   localparam int unsigned BlockOffsetLength = 3;
   localparam int unsigned ByteOffsetLength  = 3;
   localparam int unsigned SetAssociativity  = 4;

   typedef struct packed {
      logic [31:0] ByteOffsetLength;
      logic [31:0] BlockOffsetLength;
      logic [31:0] IndexLength;
   } llc_cfg_t;

   typedef struct packed {
      logic [31:0] IdWidth;
      logic [31:0] AddrWidthFull;
      logic [31:0] DataWidth;
   } llc_axi_cfg_t;

   localparam llc_cfg_t LlcCfgDefault = '{ByteOffsetLength: 32'd3, BlockOffsetLength: 32'd3,
                                          IndexLength: 32'd5};
   localparam llc_axi_cfg_t LlcAxiCfgDefault = '{IdWidth: 32'd4, AddrWidthFull: 32'd16,
                                                 DataWidth: 32'd64};

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {EvictUnit, RefilUnit, WChanUnit, RChanUnit} cache_unit_e;

   typedef struct packed {
      logic [IdWidth-1:0]          a_x_id;
      logic [AddrWidth-1:0]        a_x_addr;
      logic [7:0]                  a_x_len;
      logic [2:0]                  a_x_size;
      logic [1:0]                  a_x_burst;
      logic [1:0]                  x_resp;
      logic                        x_last;
      logic [SetAssociativity-1:0] way_ind;
      logic [IndexLength-1:0]      index_partition;
   } desc_t;

   typedef struct packed {
      cache_unit_e                 cache_unit;
      logic [SetAssociativity-1:0] way_ind;
      logic [IndexLength-1:0]      line_addr;
      logic [BlockOffsetLength-1:0] blk_offset;
      logic                        we;
      logic [DataWidth/8-1:0]      strb;
      logic [DataWidth-1:0]        data;
   } way_inp_t;

   typedef struct packed {
      cache_unit_e          cache_unit;
      logic [DataWidth-1:0] data;
   } way_oup_t;

   typedef struct packed {
      logic [IndexLength-1:0]      index;
      logic [SetAssociativity-1:0] way_ind;
   } lock_t;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [DataWidth-1:0] data;
      logic [1:0]           resp;
      logic                 last;
   } r_chan_t;
endpackage

module axi_llc_read_unit
   import axi_llc_read_pkg::*;
#(
   parameter llc_cfg_t     Cfg       = LlcCfgDefault,
   parameter llc_axi_cfg_t AxiCfg    = LlcAxiCfgDefault,
   parameter int unsigned  MetaDepth = 4
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     test_i,
   input  desc_t    desc_i,
   input  logic     desc_valid_i,
   output logic     desc_ready_o,
   output way_inp_t way_inp_o,
   output logic     way_inp_valid_o,
   input  logic     way_inp_ready_i,
   input  way_oup_t way_out_i,
   input  logic     way_out_valid_i,
   output logic     way_out_ready_o,
   output r_chan_t  r_chan_slv_o,
   output logic     r_chan_valid_o,
   input  logic     r_chan_ready_i,
   output lock_t    r_unlock_o,
   output logic     r_unlock_req_o,
   input  logic     r_unlock_gnt_i
);
   localparam int unsigned ByteOffLen = Cfg.ByteOffsetLength;
   localparam int unsigned BlkOffLen  = Cfg.BlockOffsetLength;
   localparam int unsigned IdxLen     = Cfg.IndexLength;
   localparam int unsigned AW         = AxiCfg.AddrWidthFull;
   localparam int unsigned PtrW       = (MetaDepth > 1) ? $clog2(MetaDepth) : 1;
   localparam int unsigned CntW       = $clog2(MetaDepth + 1);

   typedef enum logic {IDLE, BUSY} state_e;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic [1:0]         resp;
      logic               last;
      logic               err;
   } meta_t;

   state_e          state_q, state_d;
   desc_t           desc_q, desc_d;
   logic            issue, is_err;
   logic [AW-1:0]   num_bytes, next_addr;

   meta_t           meta_q [MetaDepth];
   meta_t           meta_in, head;
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            meta_full, meta_valid, pop;

   r_chan_t         r_in, a_q, b_q;
   logic            a_full_q, b_full_q, spill_ready, r_in_valid;
   logic            a_fill, a_drain, b_fill, b_drain;
   logic            unused_inputs;

   assign unused_inputs = ^{test_i, way_out_i.cache_unit};

   assign is_err    = (desc_q.x_resp == RESP_SLVERR);
   assign num_bytes = {{(AW-1){1'b0}}, 1'b1} << desc_q.a_x_size;
   assign next_addr = (desc_q.a_x_addr + num_bytes) & ~(num_bytes - {{(AW-1){1'b0}}, 1'b1});

   assign way_inp_o.cache_unit = RChanUnit;
   assign way_inp_o.way_ind    = desc_q.way_ind;
   assign way_inp_o.line_addr  = desc_q.index_partition[IdxLen-1:0];
   assign way_inp_o.blk_offset = desc_q.a_x_addr[ByteOffLen +: BlkOffLen];
   assign way_inp_o.we         = 1'b0;
   assign way_inp_o.strb       = '0;
   assign way_inp_o.data       = '0;

   assign r_unlock_o.index   = desc_q.index_partition;
   assign r_unlock_o.way_ind = desc_q.way_ind;

   // Issue FSM: accept descriptors, issue one beat per eligible cycle, unlock on the last beat
   always_comb begin
      state_d         = state_q;
      desc_d          = desc_q;
      desc_ready_o    = 1'b0;
      way_inp_valid_o = 1'b0;
      issue           = 1'b0;
      r_unlock_req_o  = 1'b0;
      unique case (state_q)
         IDLE: begin
            desc_ready_o = 1'b1;
            if (desc_valid_i) begin
               desc_d  = desc_i;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (r_unlock_gnt_i && !meta_full) begin
               if (is_err) begin
                  issue = 1'b1;
               end else begin
                  way_inp_valid_o = 1'b1;
                  issue           = way_inp_ready_i;
               end
               if (issue) begin
                  if (desc_q.a_x_len != '0) begin
                     desc_d.a_x_len = desc_q.a_x_len - 8'd1;
                     if (desc_q.a_x_burst != BURST_FIXED) desc_d.a_x_addr = next_addr;
                  end else begin
                     r_unlock_req_o = 1'b1;
                     desc_ready_o   = 1'b1;
                     if (desc_valid_i) desc_d = desc_i;
                     else              state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Issue FSM state and descriptor registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         desc_q  <= '0;
      end else begin
         state_q <= state_d;
         desc_q  <= desc_d;
      end
   end

   assign meta_in.id   = desc_q.a_x_id;
   assign meta_in.resp = desc_q.x_resp;
   assign meta_in.last = desc_q.x_last && (desc_q.a_x_len == '0);
   assign meta_in.err  = is_err;
   assign meta_full    = (count_q == CntW'(MetaDepth));
   assign meta_valid   = (count_q != '0);
   assign head         = meta_q[rd_ptr_q];

   // In-order beat metadata FIFO; full blocks a push even when a pop happens in the same cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < MetaDepth; i++) meta_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (issue) begin
            meta_q[wr_ptr_q] <= meta_in;
            wr_ptr_q <= (wr_ptr_q == PtrW'(MetaDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
         end
         if (pop) rd_ptr_q <= (rd_ptr_q == PtrW'(MetaDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
         if (issue && !pop)      count_q <= count_q + CntW'(1);
         else if (pop && !issue) count_q <= count_q - CntW'(1);
      end
   end

   assign r_in_valid      = meta_valid && (head.err || way_out_valid_i);
   assign spill_ready     = !a_full_q || !b_full_q;
   assign pop             = r_in_valid && spill_ready;
   assign way_out_ready_o = meta_valid && !head.err && spill_ready;
   assign r_in.id         = head.id;
   assign r_in.resp       = head.err ? RESP_SLVERR : head.resp;
   assign r_in.data       = head.err ? '0 : way_out_i.data;
   assign r_in.last       = head.last;

   // Two-slot spill register: A takes new beats, B parks the older beat while R is stalled
   assign a_fill         = pop;
   assign a_drain        = a_full_q && !b_full_q;
   assign b_fill         = a_drain && !r_chan_ready_i;
   assign b_drain        = b_full_q && r_chan_ready_i;
   assign r_chan_valid_o = a_full_q || b_full_q;
   assign r_chan_slv_o   = b_full_q ? b_q : a_q;

   // Spill register slots
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_full_q <= 1'b0;
         b_full_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         if (a_fill || a_drain) a_full_q <= a_fill || !a_drain;
         if (a_fill)            a_q      <= r_in;
         if (b_fill || b_drain) b_full_q <= b_fill || !b_drain;
         if (b_fill)            b_q      <= a_q;
      end
   end

   // Returned way data must always have a pending beat to pair with
   way_out_has_meta: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                      way_out_valid_i |-> meta_valid);
endmodule

// File: tb/tb_axi_llc_read_unit.sv
// Directed bench for axi_llc_read_unit: a way-memory responder and handshake
// recorders run alongside one linear stimulus/check sequence.
module tb_axi_llc_read_unit;
   import axi_llc_read_pkg::*;

   logic     clk = 1'b0;
   logic     rst_n = 1'b1;
   logic     test_i = 1'b0;
   desc_t    desc_i = '0;
   logic     desc_valid_i = 1'b0;
   logic     desc_ready_o;
   way_inp_t way_inp_o;
   logic     way_inp_valid_o;
   logic     way_inp_ready_i = 1'b1;
   way_oup_t way_out_i = '0;
   logic     way_out_valid_i = 1'b0;
   logic     way_out_ready_o;
   r_chan_t  r_chan_slv_o;
   logic     r_chan_valid_o;
   logic     r_chan_ready_i = 1'b1;
   lock_t    r_unlock_o;
   logic     r_unlock_req_o;
   logic     r_unlock_gnt_i = 1'b1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rsp_idx = 0;
   logic ways_hold = 1'b0;
   logic hs_req, hs_rsp;

   way_inp_t    req_log[$];
   int          req_cyc[$];
   r_chan_t     r_log[$];
   lock_t       unl_log[$];
   int          unl_cyc[$];
   int          acc_cyc[$];
   logic [63:0] pend[$];

   axi_llc_read_unit #(.MetaDepth(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .test_i(test_i),
      .desc_i(desc_i), .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
      .way_inp_o(way_inp_o), .way_inp_valid_o(way_inp_valid_o), .way_inp_ready_i(way_inp_ready_i),
      .way_out_i(way_out_i), .way_out_valid_i(way_out_valid_i), .way_out_ready_o(way_out_ready_o),
      .r_chan_slv_o(r_chan_slv_o), .r_chan_valid_o(r_chan_valid_o), .r_chan_ready_i(r_chan_ready_i),
      .r_unlock_o(r_unlock_o), .r_unlock_req_o(r_unlock_req_o), .r_unlock_gnt_i(r_unlock_gnt_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Handshakes seen at the falling edge complete at the following rising edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (way_inp_valid_o && way_inp_ready_i) begin
            req_log.push_back(way_inp_o);
            req_cyc.push_back(cyc);
         end
         if (r_chan_valid_o && r_chan_ready_i) r_log.push_back(r_chan_slv_o);
         if (r_unlock_req_o) begin
            unl_log.push_back(r_unlock_o);
            unl_cyc.push_back(cyc);
         end
         if (desc_valid_i && desc_ready_o) acc_cyc.push_back(cyc);
      end
   end

   // Way memory: returns 0xD000 + request number, one cycle after each request, in order
   always begin
      @(negedge clk);
      hs_req = rst_n && way_inp_valid_o && way_inp_ready_i;
      hs_rsp = rst_n && way_out_valid_i && way_out_ready_o;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         pend.delete();
      end else begin
         if (hs_rsp) void'(pend.pop_front());
         if (hs_req) begin
            pend.push_back(64'hD000 + 64'(rsp_idx));
            rsp_idx++;
         end
      end
      way_out_valid_i = rst_n && !ways_hold && (pend.size() != 0);
      way_out_i.data  = (pend.size() != 0) ? pend[0] : 64'h0;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic desc_t mk(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp,
                                input logic last, input logic [3:0] way, input logic [4:0] idx);
      desc_t d;
      d.a_x_id = id; d.a_x_addr = addr; d.a_x_len = len; d.a_x_size = size;
      d.a_x_burst = burst; d.x_resp = resp; d.x_last = last; d.way_ind = way;
      d.index_partition = idx;
      return d;
   endfunction

   task automatic send(input desc_t d);
      int n = 0;
      desc_i = d;
      desc_valid_i = 1'b1;
      #1;
      while (!desc_ready_o && n < 200) begin
         @(posedge clk);
         #3;
         n++;
      end
      chk("desc_accept_timeout", 64'(n < 200), 64'd1);
      tick();
      desc_valid_i = 1'b0;
   endtask

   task automatic wait_r(input int n, input string tag);
      int k = 0;
      while (r_log.size() < n && k < 300) begin
         tick();
         k++;
      end
      chk(tag, 64'(r_log.size()), 64'(n));
   endtask

   int qb, rb, ub, ab;

   initial begin
      // Reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_desc_ready", desc_ready_o, 1);
      chk("rst_way_inp_valid", way_inp_valid_o, 0);
      chk("rst_r_valid", r_chan_valid_o, 0);
      chk("rst_unlock_req", r_unlock_req_o, 0);
      chk("rst_way_out_ready", way_out_ready_o, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();

      // 1: INCR len 3 size 8B from 0x100
      qb = req_log.size(); rb = r_log.size(); ub = unl_log.size();
      send(mk(4'h3, 16'h0100, 8'd3, 3'd3, BURST_INCR, RESP_OKAY, 1'b1, 4'b0010, 5'h0A));
      wait_r(rb + 4, "t1_beats");
      chk("t1_req_count", 64'(req_log.size()), 64'(qb + 4));
      for (int k = 0; k < 4; k++) begin
         chk("t1_blk_offset", req_log[qb+k].blk_offset, 64'(k));
         chk("t1_r_data", r_log[rb+k].data, 64'h0000_0000_0000_D000 + 64'(qb + k));
         chk("t1_r_last", r_log[rb+k].last, 64'(k == 3));
      end
      chk("t1_line_addr", req_log[qb].line_addr, 5'h0A);
      chk("t1_we", req_log[qb].we, 0);
      chk("t1_unit", req_log[qb].cache_unit, RChanUnit);
      chk("t1_r_id", r_log[rb].id, 4'h3);
      chk("t1_r_resp", r_log[rb+3].resp, RESP_OKAY);
      chk("t1_unlock_count", 64'(unl_log.size()), 64'(ub + 1));
      chk("t1_unlock_index", unl_log[ub].index, 5'h0A);
      chk("t1_unlock_way", unl_log[ub].way_ind, 4'b0010);
      chk("t1_unlock_on_4th_req", 64'(unl_cyc[ub]), 64'(req_cyc[qb+3]));

      // 2: FIXED len 2, address 0x128 -> block offset 5 for every beat
      qb = req_log.size(); rb = r_log.size();
      send(mk(4'h5, 16'h0128, 8'd2, 3'd3, BURST_FIXED, RESP_OKAY, 1'b1, 4'b0100, 5'h11));
      wait_r(rb + 3, "t2_beats");
      chk("t2_req_count", 64'(req_log.size()), 64'(qb + 3));
      for (int k = 0; k < 3; k++) begin
         chk("t2_blk_offset", req_log[qb+k].blk_offset, 3'd5);
         chk("t2_r_resp", r_log[rb+k].resp, RESP_OKAY);
         chk("t2_r_last", r_log[rb+k].last, 64'(k == 2));
      end

      // 3: SLVERR descriptor, no way traffic
      qb = req_log.size(); rb = r_log.size(); ub = unl_log.size();
      send(mk(4'h9, 16'h0300, 8'd1, 3'd3, BURST_INCR, RESP_SLVERR, 1'b1, 4'b0001, 5'h02));
      wait_r(rb + 2, "t3_beats");
      chk("t3_req_count", 64'(req_log.size()), 64'(qb));
      for (int k = 0; k < 2; k++) begin
         chk("t3_r_resp", r_log[rb+k].resp, RESP_SLVERR);
         chk("t3_r_data", r_log[rb+k].data, 0);
         chk("t3_r_last", r_log[rb+k].last, 64'(k == 1));
         chk("t3_r_id", r_log[rb+k].id, 4'h9);
      end
      chk("t3_unlock_count", 64'(unl_log.size()), 64'(ub + 1));

      // 4: two single-beat fragments back to back
      rb = r_log.size(); ub = unl_log.size(); ab = acc_cyc.size();
      send(mk(4'h1, 16'h0040, 8'd0, 3'd3, BURST_INCR, RESP_OKAY, 1'b0, 4'b0001, 5'h04));
      send(mk(4'h2, 16'h0048, 8'd0, 3'd3, BURST_INCR, RESP_OKAY, 1'b1, 4'b0001, 5'h04));
      wait_r(rb + 2, "t4_beats");
      chk("t4_accept_with_unlock", 64'(acc_cyc[ab+1]), 64'(unl_cyc[ub]));
      chk("t4_unlock_count", 64'(unl_log.size()), 64'(ub + 2));
      chk("t4_last0", r_log[rb].last, 0);
      chk("t4_last1", r_log[rb+1].last, 1);
      chk("t4_id1", r_log[rb+1].id, 4'h2);

      // 5: R stalled with ways idle -> issue stops at MetaDepth outstanding beats
      qb = req_log.size(); rb = r_log.size();
      ways_hold = 1'b1;
      r_chan_ready_i = 1'b0;
      send(mk(4'h7, 16'h0000, 8'd7, 3'd3, BURST_INCR, RESP_OKAY, 1'b1, 4'b1000, 5'h1F));
      repeat (20) tick();
      chk("t5_stall_req_count", 64'(req_log.size()), 64'(qb + 4));
      chk("t5_stall_way_valid", way_inp_valid_o, 0);
      chk("t5_stall_r_valid", r_chan_valid_o, 0);
      ways_hold = 1'b0;
      r_chan_ready_i = 1'b1;
      wait_r(rb + 8, "t5_beats");
      for (int k = 0; k < 8; k++) begin
         chk("t5_r_data", r_log[rb+k].data, 64'h0000_0000_0000_D000 + 64'(qb + k));
         chk("t5_r_last", r_log[rb+k].last, 64'(k == 7));
         chk("t5_blk_offset", req_log[qb+k].blk_offset, 64'(k));
      end

      // 6: no grant -> no issue; then reset in the middle of a burst
      qb = req_log.size(); ub = unl_log.size();
      r_unlock_gnt_i = 1'b0;
      send(mk(4'h4, 16'h0200, 8'd7, 3'd3, BURST_INCR, RESP_OKAY, 1'b1, 4'b1000, 5'h03));
      repeat (5) tick();
      chk("t6_nogrant_req_count", 64'(req_log.size()), 64'(qb));
      chk("t6_nogrant_way_valid", way_inp_valid_o, 0);
      chk("t6_nogrant_unlock", 64'(unl_log.size()), 64'(ub));
      r_unlock_gnt_i = 1'b1;
      tick();
      tick();
      chk("t6_grant_req_count", 64'(req_log.size()), 64'(qb + 2));
      chk("t6_grant_way_valid", way_inp_valid_o, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_desc_ready", desc_ready_o, 1);
      chk("t6_rst_way_inp_valid", way_inp_valid_o, 0);
      chk("t6_rst_r_valid", r_chan_valid_o, 0);
      chk("t6_rst_unlock_req", r_unlock_req_o, 0);
      chk("t6_rst_way_out_ready", way_out_ready_o, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("t6_post_desc_ready", desc_ready_o, 1);
      chk("t6_post_way_inp_valid", way_inp_valid_o, 0);
      chk("t6_post_r_valid", r_chan_valid_o, 0);
      chk("t6_post_unlock_count", 64'(unl_log.size()), 64'(ub));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
